// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: PC, 1-cycle ROM latency tracking, 2-entry return buffer, redirects.
// Latency: 2 cycles from issue/redirect to out_valid; backpressure via out_ready, issue throttled by credits.

// Generic synchronous FIFO with flush; DEPTH must be a power of two.
// Latency: 1 cycle push-to-valid; a push when full is illegal, the producer must hold credits.
module fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         in_vld,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat,
   output logic [$clog2(DEPTH+1)-1:0] cnt
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt_q;
   logic          full;
   logic          push;
   logic          pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign out_vld = (cnt_q != '0);
   assign out_dat = mem[rd_ptr];
   assign cnt     = cnt_q;
   assign push    = in_vld && !flush;
   assign pop     = out_vld && out_rdy && !flush;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible while counted.
   always_ff @(posedge clk) begin
      if (!rst && push) mem[wr_ptr] <= in_dat;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush) !(in_vld && full));
endmodule

module instr_fetch_ctrl #(
   parameter int                   ADDR_BITS = 12,
   parameter int                   DATA_W    = 32,
   parameter logic [ADDR_BITS-1:0] RESET_PC  = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 redirect_valid,
   input  logic [ADDR_BITS-1:0] redirect_pc,
   output logic [ADDR_BITS-1:0] rom_addr,
   input  logic [DATA_W-1:0]    rom_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_W-1:0]    out_instr,
   output logic [ADDR_BITS-1:0] out_pc
);
   typedef struct packed {
      logic [DATA_W-1:0]    instr;
      logic [ADDR_BITS-1:0] pc;
   } fetch_ent_t;

   logic [ADDR_BITS-1:0] fetch_pc;
   logic [ADDR_BITS-1:0] inflight_pc;
   logic [ADDR_BITS-1:0] redirect_tgt;
   logic                 inflight;
   logic                 head_vld;
   logic                 pop;
   logic                 push;
   logic                 issue;
   logic [1:0]           cnt;
   logic [2:0]           credit_use;
   fetch_ent_t           push_ent;
   fetch_ent_t           head_ent;

   assign redirect_tgt = redirect_pc & ~ADDR_BITS'(3);
   assign rom_addr     = redirect_valid ? redirect_tgt : fetch_pc;

   assign pop  = head_vld && out_ready;
   // A redirect kills the word returning this cycle: it belongs to the old stream.
   assign push = inflight && !redirect_valid;

   // Buffered plus in-flight words after this cycle's pop must leave room for one more return.
   assign credit_use = 3'(cnt) + 3'(inflight) - 3'(pop);
   assign issue      = redirect_valid || (credit_use < 3'd2);

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc    <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            inflight_pc <= rom_addr;
            fetch_pc    <= rom_addr + ADDR_BITS'(4);
         end
      end
   end

   assign push_ent.instr = rom_data;
   assign push_ent.pc    = inflight_pc;

   fifo #(
      .W     ($bits(fetch_ent_t)),
      .DEPTH (2)
   ) u_buf (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect_valid),
      .in_vld  (push),
      .in_dat  (push_ent),
      .out_vld (head_vld),
      .out_rdy (out_ready),
      .out_dat (head_ent),
      .cnt     (cnt)
   );

   assign out_valid = head_vld;
   assign out_instr = head_vld ? head_ent.instr : '0;
   assign out_pc    = head_vld ? head_ent.pc    : '0;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: ROM model, queue-based fetch model checked every cycle, plus literal checkpoints.
module tb_instr_fetch_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [11:0] redirect_pc;
   logic [11:0] rom_addr;
   logic [31:0] rom_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [11:0] out_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   instr_fetch_ctrl dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   logic [31:0] rom_mem [1024];
   initial begin
      for (int i = 0; i < 1024; i++) rom_mem[i] = 32'h1000_0000 + 32'(i);
   end

   always @(posedge clk) begin
      if (rst) rom_data <= '0;
      else     rom_data <= rom_mem[rom_addr[11:2]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input logic [11:0] pc);
      return 32'h1000_0000 + 32'(pc >> 2);
   endfunction

   // Model: buffered pcs as a queue, one optional outstanding read, next sequential fetch address.
   logic [11:0] m_q[$];
   bit          m_known = 0;
   bit          m_inf;
   logic [11:0] m_inf_pc;
   logic [11:0] m_fetch;

   always @(negedge clk) begin
      logic [11:0] addr;
      bit          pop;
      bit          iss;
      int          used;
      addr = redirect_valid ? (redirect_pc & 12'hFFC) : m_fetch;
      if (m_known) begin
         chk("m_valid", 32'(out_valid), 32'(m_q.size() != 0));
         if (m_q.size() != 0) begin
            chk("m_pc", 32'(out_pc), 32'(m_q[0]));
            chk("m_instr", out_instr, word_at(m_q[0]));
         end
         chk("m_rom_addr", 32'(rom_addr), 32'(addr));
      end
      if (rst) begin
         m_q.delete();
         m_inf   = 0;
         m_fetch = 12'h000;
         m_known = 1;
      end else if (m_known) begin
         pop  = (m_q.size() != 0) && out_ready;
         used = m_q.size() + int'(m_inf) - int'(pop);
         iss  = redirect_valid || (used < 2);
         if (redirect_valid) begin
            m_q.delete();
         end else begin
            if (pop)   void'(m_q.pop_front());
            if (m_inf) m_q.push_back(m_inf_pc);
         end
         m_inf = iss;
         if (iss) begin
            m_inf_pc = addr;
            m_fetch  = addr + 12'd4;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic see(input string name, input logic exp_v, input logic [11:0] exp_pc);
      #2;
      chk({name, "_valid"}, 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
         chk({name, "_pc"}, 32'(out_pc), 32'(exp_pc));
         chk({name, "_instr"}, out_instr, word_at(exp_pc));
      end
   endtask

   logic [47:0] pat = 48'hA5F3_0C96_E1B7;

   initial begin
      rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
      repeat (3) tick();
      #2;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_pc", 32'(out_pc), 32'd0);
      chk("rst_instr", out_instr, 32'd0);

      tick(); rst = 1'b0;                    // cycle 0
      #2 chk("c0_rom_addr", 32'(rom_addr), 32'h000);
      chk("c0_valid", 32'(out_valid), 32'd0);
      tick(); see("c1", 1'b0, 12'h000);
      tick(); see("c2", 1'b1, 12'h000);
      tick(); see("c3", 1'b1, 12'h004);
      tick(); see("c4", 1'b1, 12'h008);
      repeat (3) tick();                     // cycle 7

      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         see("stall", 1'b1, 12'h014);
         tick();
      end
      out_ready = 1'b1;                      // cycle 13
      see("rel0", 1'b1, 12'h014);
      tick(); see("rel1", 1'b1, 12'h018);
      tick(); see("rel2", 1'b1, 12'h01C);
      tick(); see("rel3", 1'b1, 12'h020);

      tick();                                // cycle 17: redirect while holding
      out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 12'h101;
      see("rd_n", 1'b1, 12'h024);
      chk("rd_n_rom_addr", 32'(rom_addr), 32'h100);
      tick(); redirect_valid = 1'b0; out_ready = 1'b1;
      see("rd_n1", 1'b0, 12'h000);
      tick(); see("rd_n2", 1'b1, 12'h100);
      tick(); see("rd_n3", 1'b1, 12'h104);

      tick(); redirect_valid = 1'b1; redirect_pc = 12'hFF8;  // cycle 21
      tick(); redirect_valid = 1'b0;
      tick(); see("wrap0", 1'b1, 12'hFF8);
      tick(); see("wrap1", 1'b1, 12'hFFC);
      tick(); see("wrap2", 1'b1, 12'h000);
      tick(); see("wrap3", 1'b1, 12'h004);

      tick(); redirect_valid = 1'b1; redirect_pc = 12'h040;  // cycle 27
      tick(); redirect_pc = 12'h080;
      #2 chk("b2b_rom_addr", 32'(rom_addr), 32'h080);
      tick(); redirect_valid = 1'b0;
      see("b2b_n2", 1'b0, 12'h000);
      tick(); see("b2b_n3", 1'b1, 12'h080);
      tick(); see("b2b_n4", 1'b1, 12'h084);

      tick(); out_ready = 1'b0;              // cycle 32
      tick();
      tick(); rst = 1'b1;                    // cycle 34, FIFO holds two words
      see("pre_rst", 1'b1, 12'h088);
      tick(); rst = 1'b0; out_ready = 1'b1;
      #2;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_pc", 32'(out_pc), 32'd0);
      chk("mid_rst_instr", out_instr, 32'd0);
      tick(); see("mr1", 1'b0, 12'h000);
      tick(); see("mr2", 1'b1, 12'h000);
      tick(); see("mr3", 1'b1, 12'h004);

      for (int i = 0; i < 48; i++) begin
         tick();
         out_ready      = pat[i];
         redirect_valid = (i == 20) || (i == 33);
         redirect_pc    = (i == 20) ? 12'h3FE : 12'hFFD;
      end
      tick(); redirect_valid = 1'b0; out_ready = 1'b1;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
